// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the RV32M multiply/divide instructions.
// It accepts one request at a time. Multiplies go to an external pipelined
// unsigned multiplier, which is fed with operand magnitudes. Divides run on an
// internal restoring divider that produces one quotient bit per cycle.
// RISC-V sign correction and the div-by-zero/overflow results are applied in
// FIXUP. The result is registered, and done_o pulses for one cycle.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start_i           - request strobe, sampled only when idle
//   op_i[2:0]         - funct3 (mul, mulh, mulhsu, mulhu, div, divu, rem, remu)
//   a_i, b_i          - rs1 / rs2 operands, sampled with start_i
//   flush_i           - abort the current operation (no done, result kept)
//   mul_a_o, mul_b_o  - unsigned operand magnitudes to the external multiplier
//   mul_res_i[63:0]   - unsigned product returned by the external multiplier
//   busy_o            - high while an operation is in flight
//   done_o            - one-cycle pulse when res_o is valid
//   res_o             - registered result, held until the next accepted start
module muldiv_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [2:0]              op_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    input  logic                    flush_i,
    output logic [DATA_WIDTH-1:0]   mul_a_o,
    output logic [DATA_WIDTH-1:0]   mul_b_o,
    input  logic [2*DATA_WIDTH-1:0] mul_res_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DATA_WIDTH-1:0]   res_o
);

    localparam logic [DATA_WIDTH-1:0] AllOnes = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] MinInt  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StMulWait, StDivIter, StFixup, StDone} state_t;

    state_t                  state;
    logic [5:0]              cnt;
    logic [2:0]              op;
    logic [DATA_WIDTH-1:0]   a_orig;
    logic [DATA_WIDTH-1:0]   quo;
    logic [DATA_WIDTH-1:0]   rem;
    logic                    neg_res;
    logic                    div_zero;
    logic                    ovf;

    // Request decode (used only in the accept cycle)
    logic                    sign_a_en, sign_b_en, sign_a, sign_b;
    logic [DATA_WIDTH-1:0]   mag_a, mag_b;
    logic                    neg_in, div_zero_in, ovf_in;

    always_comb begin
        sign_a_en = 1'b0;
        sign_b_en = 1'b0;
        unique case (op_i)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sign_a_en = 1'b1;
                sign_b_en = 1'b1;
            end
            3'b010:  sign_a_en = 1'b1;
            default: ;
        endcase
        sign_a      = sign_a_en & a_i[DATA_WIDTH-1];
        sign_b      = sign_b_en & b_i[DATA_WIDTH-1];
        mag_a       = sign_a ? -a_i : a_i;
        mag_b       = sign_b ? -b_i : b_i;
        // rem takes the dividend's sign; every other op takes the product/quotient sign
        neg_in      = (op_i[2] & op_i[1]) ? sign_a : (sign_a ^ sign_b);
        div_zero_in = op_i[2] & (b_i == '0);
        ovf_in      = op_i[2] & ~op_i[0] & (a_i == MinInt) & (b_i == AllOnes);
    end

    // One restoring-division step. The divisor lives in mul_b_o.
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH-1:0] rem_next, quo_next;

    always_comb begin
        shifted = {rem, quo[DATA_WIDTH-1]};
        if (shifted >= {1'b0, mul_b_o}) begin
            rem_next = DATA_WIDTH'(shifted - {1'b0, mul_b_o});
            quo_next = {quo[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[DATA_WIDTH-1:0];
            quo_next = {quo[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Final result selection with sign correction and the special cases.
    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]   fix_res;

    always_comb begin
        prod = neg_res ? -mul_res_i : mul_res_i;
        if (!op[2]) begin
            fix_res = (op[1:0] == 2'b00) ? prod[DATA_WIDTH-1:0] : prod[2*DATA_WIDTH-1:DATA_WIDTH];
        end else if (!op[1]) begin
            if (div_zero)  fix_res = AllOnes;
            else if (ovf)  fix_res = MinInt;
            else           fix_res = neg_res ? -quo : quo;
        end else begin
            if (div_zero)  fix_res = a_orig;
            else if (ovf)  fix_res = '0;
            else           fix_res = neg_res ? -rem : rem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            cnt      <= '0;
            op       <= '0;
            a_orig   <= '0;
            quo      <= '0;
            rem      <= '0;
            neg_res  <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            mul_a_o  <= '0;
            mul_b_o  <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            res_o    <= '0;
        end else if (flush_i) begin
            state  <= StIdle;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start_i) begin
                        op       <= op_i;
                        a_orig   <= a_i;
                        mul_a_o  <= mag_a;
                        mul_b_o  <= mag_b;
                        quo      <= mag_a;
                        rem      <= '0;
                        neg_res  <= neg_in;
                        div_zero <= div_zero_in;
                        ovf      <= ovf_in;
                        busy_o   <= 1'b1;
                        if (!op_i[2]) begin
                            state <= StMulWait;
                            cnt   <= 6'(MUL_LATENCY - 1);
                        end else if (div_zero_in || ovf_in) begin
                            state <= StFixup;
                        end else begin
                            state <= StDivIter;
                            cnt   <= 6'(DATA_WIDTH - 1);
                        end
                    end
                end
                StMulWait: begin
                    if (cnt == '0) state <= StFixup;
                    else           cnt   <= cnt - 6'd1;
                end
                StDivIter: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    if (cnt == '0) state <= StFixup;
                    else           cnt   <= cnt - 6'd1;
                end
                StFixup: begin
                    res_o  <= fix_res;
                    done_o <= 1'b1;
                    state  <= StDone;
                end
                StDone: begin
                    busy_o <= 1'b0;
                    state  <= StIdle;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with a behavioural 2-stage
// pipelined unsigned multiplier.
module tb_muldiv_ctrl;

    localparam int L = 2;
    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                           OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                           OP_REM = 3'b110, OP_REMU = 3'b111;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] mul_a_o, mul_b_o, res_o;
    logic [63:0] mul_res_i;
    logic        busy_o, done_o;

    int checks = 0;
    int errors = 0;

    muldiv_ctrl #(.DATA_WIDTH(32), .MUL_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_res_i(mul_res_i),
        .busy_o(busy_o), .done_o(done_o), .res_o(res_o)
    );

    always #5 clk = ~clk;

    // Behavioural pipelined multiplier, L register stages
    logic [63:0] pipe [L];
    always_ff @(posedge clk) begin
        pipe[0] <= {32'b0, mul_a_o} * {32'b0, mul_b_o};
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_res_i = pipe[L-1];

    // Issue one request (accepted in cycle T) and wait for done_o.
    // lat = k such that done_o is seen in cycle T+k, or -1 on timeout.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] r, output logic busy1,
                          output logic [31:0] ma1, output logic [31:0] mb1,
                          output logic [31:0] ma2, output logic [31:0] mb2,
                          output logic done_after);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = -1; r = '0; done_after = 1'b1;
        busy1 = busy_o; ma1 = mul_a_o; mb1 = mul_b_o; ma2 = '0; mb2 = '0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 2) begin ma2 = mul_a_o; mb2 = mul_b_o; end
            if (done_o) begin lat = k; r = res_o; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        done_after = done_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
        checks++; if (res_o !== 32'h0) begin errors++; $display("FAIL reset_res got %h want 0", res_o); end
        checks++; if (mul_a_o !== 32'h0 || mul_b_o !== 32'h0) begin
            errors++; $display("FAIL reset_mul_ops got %h/%h want 0/0", mul_a_o, mul_b_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_divide();
        vec_t v [9];
        int lat; logic [31:0] r, ma1, mb1, ma2, mb2; logic busy1, da;
        v[0] = '{"div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34};
        v[1] = '{"rem_m7_2",   OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34};
        v[2] = '{"divu_100_7", OP_DIVU, 32'd100,      32'd7, 32'd14,       34};
        v[3] = '{"remu_100_7", OP_REMU, 32'd100,      32'd7, 32'd2,        34};
        v[4] = '{"divu_5_0",   OP_DIVU, 32'd5,        32'd0, 32'hFFFFFFFF, 2};
        v[5] = '{"remu_5_0",   OP_REMU, 32'd5,        32'd0, 32'd5,        2};
        v[6] = '{"div_m7_0",   OP_DIV,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 2};
        v[7] = '{"div_ovf",    OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
        v[8] = '{"rem_ovf",    OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0, 2};
        for (int i = 0; i < 9; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, lat, r, busy1, ma1, mb1, ma2, mb2, da);
            checks++; if (r !== v[i].exp) begin
                errors++; $display("FAIL %s res got %h want %h", v[i].name, r, v[i].exp);
            end
            checks++; if (lat != v[i].lat) begin
                errors++; $display("FAIL %s latency got %0d want %0d", v[i].name, lat, v[i].lat);
            end
            checks++; if (busy1 !== 1'b1 || da !== 1'b0) begin
                errors++; $display("FAIL %s busy/done_pulse got busy=%b done_after=%b want 1/0",
                                   v[i].name, busy1, da);
            end
        end
    endtask

    task automatic test_mul();
        vec_t v [5];
        int lat; logic [31:0] r, ma1, mb1, ma2, mb2; logic busy1, da;
        v[0] = '{"mul_m1_m1",    OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        4};
        v[1] = '{"mulh_m1_m1",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        4};
        v[2] = '{"mulhsu_m1_ff", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4};
        v[3] = '{"mulhu_ff_ff",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4};
        v[4] = '{"mul_m3_5",     OP_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 4};
        for (int i = 0; i < 5; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, lat, r, busy1, ma1, mb1, ma2, mb2, da);
            checks++; if (r !== v[i].exp) begin
                errors++; $display("FAIL %s res got %h want %h", v[i].name, r, v[i].exp);
            end
            checks++; if (lat != v[i].lat || da !== 1'b0) begin
                errors++; $display("FAIL %s latency got %0d done_after=%b want %0d/0",
                                   v[i].name, lat, da, v[i].lat);
            end
            if (i < 2) begin
                checks++; if (ma1 !== 32'h1 || mb1 !== 32'h1 || ma2 !== 32'h1 || mb2 !== 32'h1) begin
                    errors++; $display("FAIL %s mul_ops got %h/%h then %h/%h want 1/1 stable",
                                       v[i].name, ma1, mb1, ma2, mb2);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt, done_at; logic [31:0] r;
        done_cnt = 0; done_at = -1; r = '0;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = OP_DIV; a_i = 32'd100; b_i = 32'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (done_o) begin
                done_cnt++;
                if (done_at < 0) begin done_at = k; r = res_o; end
            end
            if (k == 5) begin start_i = 1'b1; op_i = OP_MUL; a_i = 32'd3; b_i = 32'd4; end
            if (k == 6) start_i = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", done_cnt); end
        checks++; if (done_at != 34) begin errors++; $display("FAIL b2b_done_cycle got %0d want 34", done_at); end
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL b2b_res got %h want %h", r, 32'd14); end
    endtask

    task automatic test_flush();
        int lat, early; logic [31:0] r, ma1, mb1, ma2, mb2; logic busy1, da;
        run_op(OP_REMU, 32'd100, 32'd7, lat, r, busy1, ma1, mb1, ma2, mb2, da);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL flush_pre_res got %h want 2", r); end
        early = 0;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = OP_DIV; a_i = 32'd100; b_i = 32'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k <= 12 && done_o) early++;
            if (k == 11) begin
                checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy_o); end
                checks++; if (res_o !== 32'd2) begin errors++; $display("FAIL flush_res_kept got %h want 2", res_o); end
            end
            if (k == 12) begin
                checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL flush_restart_busy got %b want 1", busy_o); end
            end
            if (k == 13) begin
                checks++; if (done_o !== 1'b1 || res_o !== 32'hFFFFFFFF) begin
                    errors++; $display("FAIL flush_restart_done got done=%b res=%h want 1/ffffffff", done_o, res_o);
                end
            end
            if (k == 10) begin
                flush_i = 1'b1; start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd5; b_i = 32'd0;
            end
            if (k == 11) flush_i = 1'b0;
            if (k == 12) start_i = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL flush_no_done got %0d pulses want 0", early); end
    endtask

    task automatic test_reset_mid();
        int lat, dones; logic [31:0] r, ma1, mb1, ma2, mb2; logic busy1, da;
        dones = 0;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = OP_DIV; a_i = 32'd100; b_i = 32'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (done_o) dones++;
            if (k == 21) begin
                checks++; if (busy_o !== 1'b0 || res_o !== 32'h0) begin
                    errors++; $display("FAIL rst_mid_state got busy=%b res=%h want 0/0", busy_o, res_o);
                end
            end
            if (k == 20) rst = 1'b1;
            if (k == 21) rst = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d want 0", dones); end
        run_op(OP_MUL, 32'd3, 32'd4, lat, r, busy1, ma1, mb1, ma2, mb2, da);
        checks++; if (r !== 32'd12 || lat != 4) begin
            errors++; $display("FAIL rst_mid_mul got res=%h lat=%0d want 0000000c/4", r, lat);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_divide();
        test_mul();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
